// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// State codes are plain 3-bit constants so debug tooling can decode state_o directly.
package fetch_ctrl_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned TO_W = 8;

    localparam logic [XLEN-1:0] DEF_RESET_PC      = 32'h0000_0000;
    localparam int unsigned     DEF_FETCH_TIMEOUT = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_EXEC  = 3'd2;
    localparam state_t ST_HALT  = 3'd3;
    localparam state_t ST_ERROR = 3'd4;

endpackage

// File: rtl/fetch_ctrl_pc_next_unit.sv
// Next-PC selection: branch target or sequential increment, both modulo 2^XLEN.
module pc_next_unit
    import fetch_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_offset,
    output logic [XLEN-1:0] pc_nxt
);

    always_comb begin
        pc_nxt = br_taken ? (pc + br_offset) : (pc + XLEN'(1));
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch/execute sequencing FSM with a fetch timeout watchdog and a retired-instruction counter.
// HALT and ERROR are terminal; only reset leaves them.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = DEF_RESET_PC,
    parameter int unsigned FETCH_TIMEOUT = DEF_FETCH_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_ready,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic        stall,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic        instr_valid,
    output logic [31:0] instret,
    output logic        fetch_err,
    output logic [2:0]  state_o
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instret_q, instret_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              fetch_err_q, fetch_err_d;
    logic              imem_req_q, instr_valid_q;
    logic [XLEN-1:0]   pc_nxt_w;

    pc_next_unit u_pc_next (
        .pc        (pc_q),
        .br_taken  (br_taken),
        .br_offset (br_offset),
        .pc_nxt    (pc_nxt_w)
    );

    // Next-state, PC, counters; branch/stall/halt only matter in EXEC, imem_ready only in FETCH
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instret_d   = instret_q;
        to_cnt_d    = to_cnt_q;
        fetch_err_d = fetch_err_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ready) begin
                    state_d  = ST_EXEC;
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d     = ST_ERROR;
                    fetch_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    instret_d = instret_q + XLEN'(1);
                    if (halt) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                        pc_d    = pc_nxt_w;
                    end
                end
            end
            default: ;
        endcase
    end

    // Moore strobes are registered from the next state so they line up with state_q
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instret_q     <= '0;
            to_cnt_q      <= '0;
            fetch_err_q   <= 1'b0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instret_q     <= instret_d;
            to_cnt_q      <= to_cnt_d;
            fetch_err_q   <= fetch_err_d;
            imem_req_q    <= (state_d == ST_FETCH);
            instr_valid_q <= (state_d == ST_EXEC);
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign instret     = instret_q;
    assign fetch_err   = fetch_err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequencing, branches, wrap, stall/halt, reset and fetch timeout.
module tb_fetch_ctrl;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_HALT  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ready;
    logic        br_taken;
    logic [31:0] br_offset;
    logic        stall;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic        instr_valid;
    logic [31:0] instret;
    logic        fetch_err;
    logic [2:0]  state_o;

    int tests = 0;
    int fails = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_ready  (imem_ready),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .stall       (stall),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .pc          (pc),
        .instr_valid (instr_valid),
        .instret     (instret),
        .fetch_err   (fetch_err),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full status snapshot: state, pc, instret, fetch_err plus Moore strobes
    task automatic chk_all(input string tag, input logic [2:0] st, input logic [31:0] epc,
                           input logic [31:0] eret, input logic eerr);
        chk({tag, ".state"},   32'(state_o), 32'(st));
        chk({tag, ".pc"},      pc, epc);
        chk({tag, ".addr"},    imem_addr, epc);
        chk({tag, ".instret"}, instret, eret);
        chk({tag, ".err"},     32'(fetch_err), 32'(eerr));
        chk({tag, ".req"},     32'(imem_req), 32'(st == S_FETCH));
        chk({tag, ".valid"},   32'(instr_valid), 32'(st == S_EXEC));
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b1; br_taken = 1'b0; br_offset = 32'h0;
        stall = 1'b0; halt = 1'b0;
        tick(); tick();
        chk_all("reset", S_IDLE, 32'h0, 32'h0, 1'b0);

        // Sequential run with zero-wait memory
        rst_n = 1'b1;
        tick(); chk_all("seq.f0", S_FETCH, 32'h0, 32'h0, 1'b0);
        tick(); chk_all("seq.e0", S_EXEC,  32'h0, 32'h0, 1'b0);
        tick(); chk_all("seq.f1", S_FETCH, 32'h1, 32'h1, 1'b0);
        tick(); chk_all("seq.e1", S_EXEC,  32'h1, 32'h1, 1'b0);
        tick(); tick(); chk_all("seq.e2", S_EXEC, 32'h2, 32'h2, 1'b0);
        tick(); tick(); chk_all("seq.e3", S_EXEC, 32'h3, 32'h3, 1'b0);

        // Forward branch 3+13 = 0x10; branch inputs held during FETCH must be ignored
        br_taken = 1'b1; br_offset = 32'h0000_000D;
        tick(); chk_all("br.f10", S_FETCH, 32'h10, 32'h4, 1'b0);
        tick(); chk_all("br.e10", S_EXEC,  32'h10, 32'h4, 1'b0);
        br_offset = 32'hFFFF_FFFC;
        tick(); chk_all("br.back", S_FETCH, 32'h0C, 32'h5, 1'b0);
        tick(); chk_all("br.e0c", S_EXEC, 32'h0C, 32'h5, 1'b0);
        br_offset = 32'hFFFF_FFF3;
        tick(); chk_all("br.fmax", S_FETCH, 32'hFFFF_FFFF, 32'h6, 1'b0);
        br_taken = 1'b0;
        tick(); tick(); chk_all("wrap.f", S_FETCH, 32'h0, 32'h7, 1'b0);
        tick(); chk_all("wrap.e", S_EXEC, 32'h0, 32'h7, 1'b0);

        // Stall dominates halt and branch
        stall = 1'b1; halt = 1'b1; br_taken = 1'b1; br_offset = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all("stall", S_EXEC, 32'h0, 32'h7, 1'b0);
        end
        stall = 1'b0;
        tick(); chk_all("halt", S_HALT, 32'h0, 32'h8, 1'b0);
        tick(); tick(); chk_all("halt.hold", S_HALT, 32'h0, 32'h8, 1'b0);

        // Reset mid-stall discards pending update
        rst_n = 1'b0; halt = 1'b0; br_taken = 1'b0;
        tick(); chk_all("rst2", S_IDLE, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        chk_all("pre.stall", S_EXEC, 32'h1, 32'h1, 1'b0);
        stall = 1'b1;
        tick(); chk_all("mid.stall", S_EXEC, 32'h1, 32'h1, 1'b0);
        rst_n = 1'b0;
        tick(); chk_all("rst.stall", S_IDLE, 32'h0, 32'h0, 1'b0);
        stall = 1'b0;

        // Timeout: 16 FETCH cycles with no ready -> ERROR
        imem_ready = 1'b0; rst_n = 1'b1;
        tick(); chk_all("to.f1", S_FETCH, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        chk_all("to.f16", S_FETCH, 32'h0, 32'h0, 1'b0);
        tick(); chk_all("to.err", S_ERROR, 32'h0, 32'h0, 1'b1);
        imem_ready = 1'b1;
        tick(); tick(); chk_all("to.sticky", S_ERROR, 32'h0, 32'h0, 1'b1);
        rst_n = 1'b0;
        tick(); chk_all("to.rst", S_IDLE, 32'h0, 32'h0, 1'b0);

        // Ready arriving on the 16th FETCH cycle wins over timeout
        imem_ready = 1'b0; rst_n = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk_all("late.f16", S_FETCH, 32'h0, 32'h0, 1'b0);
        imem_ready = 1'b1;
        tick(); chk_all("late.exec", S_EXEC, 32'h0, 32'h0, 1'b0);
        tick(); chk_all("late.f1", S_FETCH, 32'h1, 32'h1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, word address loaded into pc on reset.
REQ-002 SHALL have parameter FETCH_TIMEOUT, 16, maximum FETCH cycles without imem_ready before error (legal range 2..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 SHALL have port imem_ready  input  1  instruction memory has returned the word at imem_addr.
REQ-006 SHALL have port br_taken  input  1  current instruction redirects PC, valid in EXEC.
REQ-007 SHALL have port br_offset  input  32  signed word offset added to pc when br_taken.
REQ-008 SHALL have port stall  input  1  hold current instruction in EXEC.
REQ-009 SHALL have port halt  input  1  current instruction stops the processor after retiring.
REQ-010 SHALL have port imem_req  output  1  fetch request, high exactly while in FETCH.
REQ-011 SHALL have port imem_addr  output  32  equals pc.
REQ-012 SHALL have port pc  output  32  current word-addressed program counter.
REQ-013 SHALL have port instr_valid  output  1  high exactly while in EXEC.
REQ-014 SHALL have port instret  output  32  count of retired instructions.
REQ-015 SHALL have port fetch_err  output  1  sticky fetch-timeout flag.
REQ-016 SHALL have port state_o  output  3  current FSM state encoding for debug.

Function
REQ-017 SHALL implement states IDLE, FETCH, EXEC, HALT, ERROR; imem_req and instr_valid are Moore outputs decoded from state.
REQ-018 IDLE SHALL transition to FETCH unconditionally on the first clock after rst_n is high.
REQ-019 In FETCH, imem_ready=1 SHALL move to EXEC next cycle and clear the timeout counter.
REQ-020 In FETCH, each cycle with imem_ready=0 SHALL increment the 8-bit timeout counter.
REQ-021 When the counter equals FETCH_TIMEOUT-1 and imem_ready=0, SHALL move to ERROR and set fetch_err.
REQ-022 imem_ready=1 on the same cycle as the timeout condition SHALL win: transition to EXEC, no error.
REQ-023 In EXEC, priority SHALL be stall > halt > br_taken > sequential.
REQ-024 EXEC with stall=1 SHALL remain in EXEC; pc and instret unchanged; br_taken and halt ignored.
REQ-025 EXEC with stall=0, halt=1 SHALL go to HALT, increment instret, leave pc unchanged.
REQ-026 EXEC with stall=0, halt=0 SHALL go to FETCH, increment instret, load pc with pc+br_offset if br_taken else pc+1.
REQ-027 PC arithmetic SHALL be 32-bit modulo 2^32 (0xFFFF_FFFF+1 = 0; negative br_offset in two's complement).
REQ-028 instret SHALL wrap from 0xFFFF_FFFF to 0 without flag.
REQ-029 br_taken, br_offset, halt and stall SHALL be ignored in every state except EXEC; imem_ready is ignored outside FETCH.
REQ-030 HALT and ERROR SHALL be terminal: outputs hold and are left only by reset.
REQ-031 Latency SHALL be at least 2 cycles per instruction (one FETCH and one EXEC) with zero-wait memory.

Reset
REQ-032 rst_n=0 at posedge clk SHALL force state IDLE, pc=RESET_PC, instret=0, fetch_err=0, timeout counter=0, imem_req=0, instr_valid=0.
REQ-033 Reset asserted in any state, including mid-FETCH or mid-stall, SHALL take effect on that edge with no pending update surviving.

Structure
REQ-034 Package fetch_ctrl_pkg SHALL hold the state enum (3-bit), XLEN=32 and default RESET_PC/FETCH_TIMEOUT constants.
REQ-035 The next-PC adder/mux SHALL be a combinational sub-module pc_next_unit (pc, br_taken, br_offset -> pc_nxt).
REQ-036 The FSM, timeout counter and instret counter SHALL reside in fetch_ctrl.

Verification
REQ-037 Reset then imem_ready always 1, no branches -> pc 0,1,2,3 on successive EXEC; instret=3 after third retire.
REQ-038 pc=0x10 in EXEC, br_taken=1, br_offset=0xFFFF_FFFC -> next FETCH imem_addr=0x0C.
REQ-039 imem_ready held 0 with FETCH_TIMEOUT=16 -> ERROR entered after 16 FETCH cycles, fetch_err=1 until rst_n=0.
REQ-040 EXEC with stall=1 for 3 cycles plus halt=1 and br_taken=1 -> pc, instret unchanged for those cycles; after stall drops -> HALT, instret+1.
REQ-041 pc=0xFFFF_FFFF sequential retire -> pc=0; rst_n=0 during stall -> next cycle IDLE, pc=RESET_PC, instret=0.
REQ-042 imem_ready=1 on 16th FETCH cycle -> EXEC entered, fetch_err stays 0.
